jedro_1_csr_exec: RTL and testbench

CSR instruction execution unit for the jedro_1 core. Accepts decoded CSRRW/CSRRS/CSRRC and their immediate forms from decode, performs the read-modify-write sequence against the CSR register file over its address/data/write-enable port, and returns the old CSR value for register writeback. It sits directly upstream of the CSR file. It is the only master of that file's read/write port.

---
 rtl/jedro_1_csr_exec.sv | 146 ++++++++++++++
 tb/tb_jedro_1_csr_exec.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jedro_1_csr_exec.sv
// jedro_1 CSR execution unit: read-modify-write sequencer
// sitting between decode and the CSR register file.
module jedro_1_csr_exec #(
  parameter int DATA_WIDTH     = 32,
  parameter int CSR_ADDR_WIDTH = 12,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [2:0]                req_funct3_i,
  input  logic [CSR_ADDR_WIDTH-1:0] req_csr_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] req_rs1_addr_i,
  input  logic [DATA_WIDTH-1:0]     req_rs1_data_i,
  input  logic [REG_ADDR_WIDTH-1:0] req_rd_addr_i,
  output logic [CSR_ADDR_WIDTH-1:0] csr_addr_o,
  output logic [DATA_WIDTH-1:0]     csr_data_o,
  output logic                      csr_we_o,
  input  logic [DATA_WIDTH-1:0]     csr_data_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [REG_ADDR_WIDTH-1:0] rsp_rd_addr_o,
  output logic [DATA_WIDTH-1:0]     rsp_rd_data_o,
  output logic                      rsp_rd_we_o,
  output logic                      rsp_illegal_o
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic [2:0]                funct3_q;
  logic [REG_ADDR_WIDTH-1:0] rs1_addr_q;
  logic [DATA_WIDTH-1:0]     rs1_data_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic [CSR_ADDR_WIDTH-1:0] csr_addr_q;

  logic [REG_ADDR_WIDTH-1:0] rsp_rd_addr_q;
  logic [DATA_WIDTH-1:0]     rsp_rd_data_q;
  logic                      rsp_rd_we_q;
  logic                      rsp_illegal_q;

  logic                  accept;
  logic                  wr_en;
  logic                  illegal;
  logic                  read_only;
  logic [DATA_WIDTH-1:0] src;
  logic [DATA_WIDTH-1:0] new_val;

  assign accept    = (state_q == IDLE) && req_valid_i;
  assign read_only = &csr_addr_q[CSR_ADDR_WIDTH-1 -: 2];

  // Operand selection, write-enable and legality decode
  always_comb begin
    src     = funct3_q[2]
            ? {{(DATA_WIDTH-REG_ADDR_WIDTH){1'b0}}, rs1_addr_q}
            : rs1_data_q;
    wr_en   = (funct3_q[1:0] == 2'b01) || (rs1_addr_q != '0);
    illegal = (funct3_q[1:0] == 2'b00) || (wr_en && read_only);
    new_val = src;
    unique case (funct3_q[1:0])
      2'b10:   new_val = csr_data_i | src;
      2'b11:   new_val = csr_data_i & ~src;
      default: new_val = src;
    endcase
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    csr_we_o    = 1'b0;
    csr_data_o  = '0;
    rsp_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = READ;
      end
      READ: begin
        state_d = WRITE;
      end
      WRITE: begin
        csr_data_o = new_val;
        csr_we_o   = wr_en && !illegal;
        state_d    = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Request capture; the CSR address also drives the file port
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      funct3_q   <= '0;
      rs1_addr_q <= '0;
      rs1_data_q <= '0;
      rd_q       <= '0;
      csr_addr_q <= '0;
    end else if (accept) begin
      funct3_q   <= req_funct3_i;
      rs1_addr_q <= req_rs1_addr_i;
      rs1_data_q <= req_rs1_data_i;
      rd_q       <= req_rd_addr_i;
      csr_addr_q <= req_csr_addr_i;
    end
  end

  // Response latch at the end of WRITE, held through RESP
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_rd_addr_q <= '0;
      rsp_rd_data_q <= '0;
      rsp_rd_we_q   <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else if (state_q == WRITE) begin
      rsp_rd_addr_q <= rd_q;
      rsp_rd_data_q <= csr_data_i;
      rsp_rd_we_q   <= (rd_q != '0) && !illegal;
      rsp_illegal_q <= illegal;
    end
  end

  assign csr_addr_o    = csr_addr_q;
  assign rsp_rd_addr_o = rsp_rd_addr_q;
  assign rsp_rd_data_o = rsp_rd_data_q;
  assign rsp_rd_we_o   = rsp_rd_we_q;
  assign rsp_illegal_o = rsp_illegal_q;

endmodule

// File: tb/tb_jedro_1_csr_exec.sv
// Bench for jedro_1_csr_exec: directed cases plus random
// CSR ops checked against an architectural CSR model.
module tb_jedro_1_csr_exec;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_csr_addr;
  logic [4:0]  req_rs1_addr;
  logic [31:0] req_rs1_data;
  logic [4:0]  req_rd_addr;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_we;
  logic [31:0] csr_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_rd_addr;
  logic [31:0] rsp_rd_data;
  logic        rsp_rd_we;
  logic        rsp_illegal;

  int total = 0;
  int bad   = 0;

  logic        csr_init;
  logic [31:0] mem  [0:4095];
  logic [31:0] refm [0:4095];
  logic [11:0] addr_set [0:5];

  jedro_1_csr_exec dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_funct3_i   (req_funct3),
    .req_csr_addr_i (req_csr_addr),
    .req_rs1_addr_i (req_rs1_addr),
    .req_rs1_data_i (req_rs1_data),
    .req_rd_addr_i  (req_rd_addr),
    .csr_addr_o     (csr_addr),
    .csr_data_o     (csr_wdata),
    .csr_we_o       (csr_we),
    .csr_data_i     (csr_rdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_rd_addr_o  (rsp_rd_addr),
    .rsp_rd_data_o  (rsp_rd_data),
    .rsp_rd_we_o    (rsp_rd_we),
    .rsp_illegal_o  (rsp_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR file: registered read, write on the edge
  always @(posedge clk) begin
    if (csr_init) begin
      mem[12'h300] <= 32'h0;
      mem[12'h305] <= 32'h0000_0100;
      mem[12'h340] <= 32'h1234_5678;
      mem[12'h341] <= 32'h0;
      mem[12'hC00] <= 32'h0000_0042;
      mem[12'hF11] <= 32'h0000_0602;
      csr_rdata    <= 32'h0;
    end else begin
      if (csr_we) mem[csr_addr] <= csr_wdata;
      csr_rdata <= mem[csr_addr];
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".rdy"},  32'(req_ready),   32'd1);
    check({tag, ".addr"}, 32'(csr_addr),    32'd0);
    check({tag, ".wd"},   csr_wdata,        32'd0);
    check({tag, ".we"},   32'(csr_we),      32'd0);
    check({tag, ".vld"},  32'(rsp_valid),   32'd0);
    check({tag, ".rd"},   32'(rsp_rd_addr), 32'd0);
    check({tag, ".data"}, rsp_rd_data,      32'd0);
    check({tag, ".rdwe"}, 32'(rsp_rd_we),   32'd0);
    check({tag, ".ill"},  32'(rsp_illegal), 32'd0);
  endtask

  // Architectural expectation for one CSR instruction
  task automatic model(input logic [2:0] f3, input logic [11:0] a,
                       input logic [4:0] r1, input logic [31:0] d1,
                       output logic [31:0] old, output logic [31:0] nv,
                       output logic we, output logic ill);
    logic [31:0] src;
    int kind;
    kind = int'(f3) % 4;
    src  = (f3 >= 3'd4) ? 32'(r1) : d1;
    old  = refm[a];
    we   = (kind == 1) || (r1 != 5'd0);
    ill  = (kind == 0) || (we && a >= 12'hC00);
    if (kind == 2)      nv = old | src;
    else if (kind == 3) nv = old & ~src;
    else                nv = src;
    if (ill) we = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [11:0] a,
                        input logic [4:0] r1, input logic [31:0] d1,
                        input logic [4:0] rd, input int hold);
    logic [31:0] old, nv;
    logic we, ill, rdwe;
    model(f3, a, r1, d1, old, nv, we, ill);
    rdwe = (rd != 5'd0) && !ill;
    check("idle.rdy", 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_funct3   = f3;
    req_csr_addr = a;
    req_rs1_addr = r1;
    req_rs1_data = d1;
    req_rd_addr  = rd;
    rsp_ready    = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("read.rdy",  32'(req_ready), 32'd0);
    check("read.addr", 32'(csr_addr),  32'(a));
    check("read.we",   32'(csr_we),    32'd0);
    @(negedge clk);
    check("write.we", 32'(csr_we), 32'(we));
    if (we) check("write.data", csr_wdata, nv);
    @(negedge clk);
    check("resp.vld",  32'(rsp_valid),   32'd1);
    check("resp.rd",   32'(rsp_rd_addr), 32'(rd));
    check("resp.data", rsp_rd_data,      old);
    check("resp.rdwe", 32'(rsp_rd_we),   32'(rdwe));
    check("resp.ill",  32'(rsp_illegal), 32'(ill));
    if (hold > 0) begin
      rsp_ready    = 1'b0;
      req_valid    = 1'b1;
      req_csr_addr = a ^ 12'h001;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold.vld",  32'(rsp_valid),   32'd1);
        check("hold.rdy",  32'(req_ready),   32'd0);
        check("hold.we",   32'(csr_we),      32'd0);
        check("hold.data", rsp_rd_data,      old);
        check("hold.rdwe", 32'(rsp_rd_we),   32'(rdwe));
        check("hold.ill",  32'(rsp_illegal), 32'(ill));
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    if (we) refm[a] = nv;
    @(negedge clk);
    check("done.vld",  32'(rsp_valid), 32'd0);
    check("done.rdy",  32'(req_ready), 32'd1);
    check("done.addr", 32'(csr_addr),  32'(a));
  endtask

  initial begin
    logic [2:0]  f3;
    logic [11:0] a;
    logic [4:0]  r1, rd;
    addr_set[0] = 12'h300;
    addr_set[1] = 12'h305;
    addr_set[2] = 12'h340;
    addr_set[3] = 12'h341;
    addr_set[4] = 12'hC00;
    addr_set[5] = 12'hF11;
    for (int i = 0; i < 4096; i++) refm[i] = 32'h0;
    refm[12'h305] = 32'h0000_0100;
    refm[12'h340] = 32'h1234_5678;
    refm[12'hC00] = 32'h0000_0042;
    refm[12'hF11] = 32'h0000_0602;
    rst          = 1'b1;
    csr_init     = 1'b1;
    req_valid    = 1'b0;
    req_funct3   = 3'd0;
    req_csr_addr = 12'd0;
    req_rs1_addr = 5'd0;
    req_rs1_data = 32'd0;
    req_rd_addr  = 5'd0;
    rsp_ready    = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    csr_init = 1'b0;
    rst      = 1'b0;
    @(negedge clk);

    run_op(3'b001, 12'h340, 5'd1, 32'hDEAD_BEEF, 5'd5, 0);
    run_op(3'b110, 12'h300, 5'd8, 32'h0, 5'd3, 0);
    run_op(3'b011, 12'h300, 5'd1, 32'h8, 5'd4, 0);
    check("mstatus", mem[12'h300], 32'h0);
    run_op(3'b010, 12'h340, 5'd0, 32'hFFFF_FFFF, 5'd7, 0);
    run_op(3'b001, 12'hF11, 5'd2, 32'h1111_1111, 5'd6, 0);
    run_op(3'b010, 12'hF11, 5'd0, 32'h0, 5'd6, 0);
    run_op(3'b100, 12'h340, 5'd3, 32'h5, 5'd6, 0);
    run_op(3'b111, 12'h340, 5'd0, 32'h0, 5'd0, 0);
    run_op(3'b101, 12'h341, 5'd9, 32'h0, 5'd1, 5);

    // Reset during WRITE must suppress the CSR update
    check("rst.rdy0", 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_funct3   = 3'b001;
    req_csr_addr = 12'h340;
    req_rs1_addr = 5'd2;
    req_rs1_data = 32'hA5A5_0F0F;
    req_rd_addr  = 5'd8;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rst.wepre", 32'(csr_we), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rstmid");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst.mem", mem[12'h340], refm[12'h340]);
    run_op(3'b001, 12'h340, 5'd2, 32'h0BAD_F00D, 5'd8, 0);

    for (int n = 0; n < 200; n++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = addr_set[$urandom_range(0, 5)];
      r1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      run_op(f3, a, r1, $urandom,
             rd, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end

    for (int i = 0; i < 6; i++)
      check("final.mem", mem[addr_set[i]], refm[addr_set[i]]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
